// File: rtl/comp_serial_seq.sv
// Serial unsigned magnitude comparator: walks A and B two bits at a time, MSB slice first.
// Optional macro COMP_SERIAL_EARLY_EXIT_EN stops at the first unequal slice instead of scanning all slices.
module comp_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_gt_B,
  output logic             A_lt_B,
  output logic             A_eq_B,
  output logic [1:0]       state_dbg
);

  localparam int NS = WIDTH / 2;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       sa;
  logic [1:0]       sb;
  logic             s_gt;
  logic             s_lt;

  assign sa        = a_q[{idx, 1'b0} +: 2];
  assign sb        = b_q[{idx, 1'b0} +: 2];
  assign s_gt      = (sa > sb);
  assign s_lt      = (sa < sb);
  assign state_dbg = state;

`ifndef COMP_SERIAL_EARLY_EXIT_EN
  // The first unequal slice seen (most significant) is remembered and wins over later slices.
  logic pend_gt;
  logic pend_lt;
  logic fin_gt;
  logic fin_lt;
  assign fin_gt = pend_gt | (~pend_lt & s_gt);
  assign fin_lt = pend_lt | (~pend_gt & s_lt);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      A_gt_B <= 1'b0;
      A_lt_B <= 1'b0;
      A_eq_B <= 1'b0;
`ifndef COMP_SERIAL_EARLY_EXIT_EN
      pend_gt <= 1'b0;
      pend_lt <= 1'b0;
`endif
    end else if (clear) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      A_gt_B <= 1'b0;
      A_lt_B <= 1'b0;
      A_eq_B <= 1'b0;
`ifndef COMP_SERIAL_EARLY_EXIT_EN
      pend_gt <= 1'b0;
      pend_lt <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q    <= A;
            b_q    <= B;
            idx    <= IW'(NS - 1);
            A_gt_B <= 1'b0;
            A_lt_B <= 1'b0;
            A_eq_B <= 1'b0;
            busy   <= 1'b1;
            state  <= SCAN;
`ifndef COMP_SERIAL_EARLY_EXIT_EN
            pend_gt <= 1'b0;
            pend_lt <= 1'b0;
`endif
          end
        end
        SCAN: begin
`ifdef COMP_SERIAL_EARLY_EXIT_EN
          if (s_gt || s_lt) begin
            A_gt_B <= s_gt;
            A_lt_B <= s_lt;
            done   <= 1'b1;
            state  <= DONE;
          end else if (idx == '0) begin
            A_eq_B <= 1'b1;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
`else
          if (idx == '0) begin
            A_gt_B <= fin_gt;
            A_lt_B <= fin_lt;
            A_eq_B <= ~(fin_gt | fin_lt);
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            pend_gt <= fin_gt;
            pend_lt <= fin_lt;
            idx     <= idx - 1'b1;
          end
`endif
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
